sm_accum_disp: RTL and testbench

SM_ACCUM_DISP -- requirements
Module: sm_accum_disp

---
 rtl/sm_pkg.sv | 13 +
 rtl/sm_accum_disp_if.sv | 15 +
 rtl/hex_to_sseg.sv | 31 +++
 rtl/sm_accum_disp.sv | 181 ++++++++++++++++++
 tb/tb_sm_accum_disp.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sm_pkg.sv
// Shared constants and helpers for the sign-magnitude accumulator with 7-seg display.
package sm_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'b11111110;
    localparam logic [7:0] SEG_ZERO  = 8'b10000001;

    // Number of hex digits needed to show an m-bit magnitude.
    function automatic int hex_digits(input int m);
        return (m + 3) / 4;
    endfunction

endpackage

// File: rtl/sm_accum_disp_if.sv
// Bus bundle for sm_accum_disp: raw buttons and operand in, display and accumulator out.
interface sm_accum_disp_if #(
    parameter int N    = 8,
    parameter int NDIG = 4
);
    logic [1:0]      btn;
    logic [N-1:0]    sw;
    logic [NDIG-1:0] an;
    logic [7:0]      sseg;
    logic            ovf;
    logic [N-1:0]    acc;

    modport master (output btn, sw, input an, sseg, ovf, acc);
    modport slave  (input btn, sw, output an, sseg, ovf, acc);
endinterface

// File: rtl/hex_to_sseg.sv
// Hex nibble to active-low {dp,a,b,c,d,e,f,g} segment code.
module hex_to_sseg (
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] sseg
);
    logic [6:0] seg;

    always_comb begin
        case (hex)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
    end

    assign sseg = {~dp, seg};
endmodule

// File: rtl/sm_accum_disp.sv
// Sign-magnitude accumulator driven by add/clear buttons, shown on a multiplexed 7-seg display.
// Optional button debounce is enabled by defining SM_DEBOUNCE_EN.
module sm_accum_disp
    import sm_pkg::*;
#(
    parameter int N            = 8,
    parameter int NDIG         = 4,
    parameter int REFRESH_BITS = 18,
    parameter int DB_BITS      = 20
) (
    input logic             clk,
    input logic             reset_n,
    sm_accum_disp_if.slave  bus
);
    localparam int M  = N - 1;
    localparam int HD = hex_digits(M);
    localparam int DW = $clog2(NDIG);

    if (N < 4 || N > 32 || NDIG < HD + 1 || REFRESH_BITS < 1 || DB_BITS < 1) begin : g_bad_params
        $error("sm_accum_disp: illegal parameter combination");
    end

    // ---------------- buttons ----------------
    logic [1:0] sync1, sync2, level, level_q, armed, pulse;
    logic [1:0] settle;
    logic       settled;

    assign settled = (settle == 2'd2);

    // A button only arms once it has been seen released after reset, so a
    // press held across reset never produces a pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= '0;
            sync2   <= '0;
            level_q <= '0;
            armed   <= '0;
            settle  <= '0;
        end else begin
            sync1   <= bus.btn;
            sync2   <= sync1;
            level_q <= level;
            armed   <= armed | ({2{settled}} & ~sync2 & ~level);
            if (!settled) settle <= settle + 2'd1;
        end
    end

`ifdef SM_DEBOUNCE_EN
    logic [DB_BITS-1:0] db_cnt [2];
    logic [1:0]         db_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_state <= '0;
            for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == db_state[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == '1) begin
                    db_state[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign level = db_state;
`else
    assign level = sync2;
`endif

    assign pulse = level & ~level_q & armed;

    // ---------------- accumulator ----------------
    logic [N-1:0] acc_q;
    logic         ovf_q;
    logic         a_s, b_s, res_s, sat;
    logic [M-1:0] a_m, b_m, res_m;
    logic [M:0]   sum;

    assign a_s = acc_q[N-1];
    assign a_m = acc_q[M-1:0];
    assign b_s = bus.sw[N-1];
    assign b_m = bus.sw[M-1:0];
    assign sum = {1'b0, a_m} + {1'b0, b_m};

    always_comb begin
        sat   = 1'b0;
        res_s = a_s;
        res_m = a_m;
        if (a_s == b_s) begin
            if (sum[M]) begin
                res_m = '1;
                sat   = 1'b1;
            end else begin
                res_m = sum[M-1:0];
            end
        end else if (a_m >= b_m) begin
            res_m = a_m - b_m;
        end else begin
            res_m = b_m - a_m;
            res_s = b_s;
        end
        if (res_m == '0) res_s = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (pulse[1]) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (pulse[0]) begin
            acc_q <= {res_s, res_m};
            if (sat) ovf_q <= 1'b1;
        end
    end

    assign bus.acc = acc_q;
    assign bus.ovf = ovf_q;

    // ---------------- display ----------------
    logic [REFRESH_BITS-1:0] pre;
    logic [DW-1:0]           digit;
    logic [4*NDIG-1:0]       mag_pad;
    logic [3:0]              nib;
    logic [7:0]              hex_seg, seg_next;
    logic [NDIG-1:0]         an_q;
    logic [7:0]              seg_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre   <= '0;
            digit <= '0;
        end else begin
            pre <= pre + 1'b1;
            if (pre == '1) digit <= (digit == DW'(NDIG - 1)) ? '0 : digit + 1'b1;
        end
    end

    always_comb begin
        mag_pad        = '0;
        mag_pad[M-1:0] = acc_q[M-1:0];
        nib            = '0;
        for (int unsigned k = 0; k < HD; k++)
            if (digit == DW'(k)) nib = mag_pad[4*k +: 4];
    end

    hex_to_sseg u_hex (
        .hex  (nib),
        .dp   (1'b0),
        .sseg (hex_seg)
    );

    always_comb begin
        seg_next = SEG_BLANK;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (digit == DW'(k)) begin
                if (k < HD)       seg_next = hex_seg;
                else if (k == HD) seg_next = acc_q[N-1] ? SEG_MINUS : SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_q  <= ~NDIG'(1);
            seg_q <= SEG_ZERO;
        end else begin
            an_q  <= ~(NDIG'(1) << digit);
            seg_q <= seg_next;
        end
    end

    assign bus.an   = an_q;
    assign bus.sseg = seg_q;
endmodule

// File: tb/tb_sm_accum_disp.sv
// Directed self-checking bench for sm_accum_disp (N=8, NDIG=4, REFRESH_BITS=4).
module tb_sm_accum_disp;
    localparam int N    = 8;
    localparam int NDIG = 4;
    localparam int RB   = 4;
`ifdef SM_DEBOUNCE_EN
    localparam int DBB  = 3;
    localparam int HOLD = 20;
`else
    localparam int DBB  = 20;
    localparam int HOLD = 6;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sm_accum_disp_if #(.N(N), .NDIG(NDIG)) bus ();

    sm_accum_disp #(.N(N), .NDIG(NDIG), .REFRESH_BITS(RB), .DB_BITS(DBB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic press(input int b);
        @(negedge clk);
        bus.btn[b] = 1'b1;
        repeat (HOLD) @(negedge clk);
        bus.btn = '0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic add(input logic [7:0] v);
        bus.sw = v;
        press(0);
    endtask

    task automatic wait_an(input logic [3:0] target, input string tag);
        for (int i = 0; i < 100 && bus.an !== target; i++) @(negedge clk);
        check(tag, bus.an, target);
    endtask

    initial begin
        logic [3:0] an_seq [4];
        logic [3:0] prev;
        int cnt;
        an_seq[0] = 4'b1011; an_seq[1] = 4'b0111; an_seq[2] = 4'b1110; an_seq[3] = 4'b1101;

        bus.btn = '0;
        bus.sw  = '0;
        repeat (3) @(negedge clk);
        check("rst_acc",  bus.acc, 8'h00);
        check("rst_ovf",  bus.ovf, 1'b0);
        check("rst_an",   bus.an, 4'b1110);
        check("rst_sseg", bus.sseg, 8'b10000001);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_an",   bus.an, 4'b1110);
        check("post_rst_sseg", bus.sseg, 8'b10000001);

`ifndef SM_DEBOUNCE_EN
        bus.sw = 8'h05;
        @(negedge clk);
        bus.btn[0] = 1'b1;
        @(posedge clk); #1 check("lat_e1", bus.acc, 8'h00);
        @(posedge clk); #1 check("lat_e2", bus.acc, 8'h00);
        @(posedge clk); #1 check("lat_e3", bus.acc, 8'h05);
        repeat (6) @(negedge clk);
        check("one_pulse", bus.acc, 8'h05);
        bus.btn = '0;
        repeat (HOLD) @(negedge clk);
`else
        add(8'h05);
        check("add5", bus.acc, 8'h05);
`endif
        add(8'h83);
        check("add_m3", bus.acc, 8'h02);
        add(8'h85);
        check("add_m5", bus.acc, 8'h83);
        check("ovf_clean", bus.ovf, 1'b0);
        wait_an(4'b1011, "an_sign");
        check("sign_digit", bus.sseg, 8'b11111110);
        wait_an(4'b1110, "an_d0");
        check("digit0_3", bus.sseg, 8'b10000110);
        wait_an(4'b1101, "an_d1");
        check("digit1_0", bus.sseg, 8'b10000001);
        wait_an(4'b0111, "an_d3");
        check("digit3_blank", bus.sseg, 8'hFF);

        press(1);
        check("clr", bus.acc, 8'h00);
        add(8'h05);
        wait_an(4'b1101, "an_sync");
        wait_an(4'b1110, "an_d0b");
        check("digit0_5", bus.sseg, 8'b10100100);
`ifndef SM_DEBOUNCE_EN
        bus.sw = 8'h85;
        bus.btn[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("live_update", bus.sseg, 8'b10000001);
        bus.btn = '0;
        repeat (HOLD) @(negedge clk);
`else
        add(8'h85);
`endif
        check("zero_norm", bus.acc, 8'h00);
        wait_an(4'b1011, "an_sign2");
        check("plus_blank", bus.sseg, 8'hFF);

        add(8'h7F);
        check("max", bus.acc, 8'h7F);
        add(8'h01);
        check("sat_acc", bus.acc, 8'h7F);
        check("sat_ovf", bus.ovf, 1'b1);
        add(8'h81);
        check("sticky_acc", bus.acc, 8'h7E);
        check("sticky_ovf", bus.ovf, 1'b1);
        press(1);
        check("clr_acc", bus.acc, 8'h00);
        check("clr_ovf", bus.ovf, 1'b0);
        add(8'hFF);
        add(8'h85);
        check("neg_sat_acc", bus.acc, 8'hFF);
        check("neg_sat_ovf", bus.ovf, 1'b1);
        press(1);

        add(8'h10);
        check("acc10", bus.acc, 8'h10);
        @(negedge clk);
        bus.btn = 2'b11;
        repeat (HOLD) @(negedge clk);
        bus.btn = '0;
        repeat (HOLD) @(negedge clk);
        check("clr_wins", bus.acc, 8'h00);

        wait_an(4'b1110, "an_cyc0");
        prev = bus.an;
        for (cnt = 0; cnt < 40 && bus.an === prev; cnt++) @(negedge clk);
        check("an_first", bus.an, 4'b1101);
        for (int s = 0; s < 4; s++) begin
            prev = bus.an;
            for (cnt = 0; cnt < 40 && bus.an === prev; cnt++) @(negedge clk);
            check("an_period", cnt, 16);
            check("an_value", bus.an, an_seq[s]);
        end

        bus.sw = 8'h05;
        @(negedge clk);
        bus.btn[0] = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midpress_rst", bus.acc, 8'h00);
        reset_n = 1'b1;
        repeat (3 * HOLD) @(negedge clk);
        check("held_no_add", bus.acc, 8'h00);
        bus.btn = '0;
        repeat (HOLD) @(negedge clk);
        check("release_no_add", bus.acc, 8'h00);
        add(8'h05);
        check("repress_add", bus.acc, 8'h05);

`ifdef SM_DEBOUNCE_EN
        press(1);
        bus.sw = 8'h03;
        @(negedge clk);
        bus.btn[0] = 1'b1;
        repeat (5) @(negedge clk);
        bus.btn = '0;
        repeat (20) @(negedge clk);
        check("glitch_ignored", bus.acc, 8'h00);
        add(8'h03);
        check("db_one_add", bus.acc, 8'h03);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end
endmodule
